// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1:2 stream demultiplexer.
// Word width, buffer depth and channel-select encoding live here.
package demux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 2;

    typedef logic [DEF_WIDTH-1:0] word_t;

    // s=1 steers to channel 0, s=0 steers to channel 1
    typedef enum logic {
        CH1 = 1'b0,
        CH0 = 1'b1
    } chan_e;

endpackage

// File: rtl/stream_fifo.sv
// Per-channel circular buffer with registered head output.
// Push into a full buffer is dropped even if a pop happens that cycle.
module stream_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Empty buffer presents zero rather than stale storage
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rptr];
        end
    end

    // Storage, power-of-two pointers that wrap naturally, occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux1_2_stream.sv
// 1:2 stream demultiplexer: steers each accepted word to one of
// two buffered output channels and counts words per channel.
module demux1_2_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [WIDTH-1:0] y1,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1
);

    chan_e sel;
    logic  full0;
    logic  full1;
    logic  empty0;
    logic  empty1;
    logic  push0;
    logic  push1;

    assign sel = chan_e'(s);

    // Ready depends only on the selected buffer's own fullness
    always_comb begin
        in_ready = 1'b0;
        push0    = 1'b0;
        push1    = 1'b0;
        unique case (sel)
            CH0: begin
                in_ready = !full0;
                push0    = in_valid && !full0;
            end
            CH1: begin
                in_ready = !full1;
                push1    = in_valid && !full1;
            end
        endcase
    end

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (push0),
        .pop   (y0_ready),
        .din   (d),
        .full  (full0),
        .empty (empty0),
        .head  (y0)
    );

    stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (push1),
        .pop   (y1_ready),
        .din   (d),
        .full  (full1),
        .empty (empty1),
        .head  (y1)
    );

    assign y0_valid = !empty0;
    assign y1_valid = !empty1;

    // Per-channel acceptance counters, wrapping modulo 256
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (push0) begin
                cnt0 <= cnt0 + 8'd1;
            end
            if (push1) begin
                cnt1 <= cnt1 + 8'd1;
            end
        end
    end

endmodule

// File: doc/demux1_2_stream.md
DEMUX1_2_STREAM -- requirements
Module: demux1_2_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width.
REQ-002 SHALL have parameter DEPTH, default 2, meaning entries per output buffer (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s  input  1  route select: 1 steers to channel 0, 0 steers to channel 1.
REQ-006 SHALL have port in_valid  input  1  input word present.
REQ-007 SHALL have port in_ready  output  1  input word accepted this cycle if in_valid.
REQ-008 SHALL have port d  input  WIDTH  input data word.
REQ-009 SHALL have ports y0_valid / y1_valid  output  1  channel holds a word.
REQ-010 SHALL have ports y0_ready / y1_ready  input  1  consumer takes head word.
REQ-011 SHALL have ports y0 / y1  output  WIDTH  channel head word.
REQ-012 SHALL have ports cnt0 / cnt1  output  8  words accepted into each channel, modulo 256.

Function
REQ-013 SHALL accept (push) when in_valid && in_ready at a rising clk edge, writing d into the buffer selected by s.
REQ-014 SHALL drive in_ready = 1 iff the buffer selected by the current s is not full; no combinational path from y0_ready/y1_ready to in_ready.
REQ-015 SHALL NOT accept into a full buffer even if that buffer pops in the same cycle.
REQ-016 SHALL present a pushed word on yN/yN_valid exactly one cycle after acceptance when the buffer was empty (latency 1, no bypass).
REQ-017 SHALL pop channel N when yN_valid && yN_ready; the next word (if any) appears on yN the following cycle.
REQ-018 SHALL hold yN stable while yN_valid=1 and yN_ready=0.
REQ-019 SHALL preserve per-channel order; no ordering guarantee between channels.
REQ-020 SHALL allow push and pop on the same buffer in one cycle when not full; occupancy unchanged.
REQ-021 SHALL allow push to one channel and pop from the other in the same cycle independently.
REQ-022 SHALL drive yN_valid=0 and yN=0 when buffer N is empty (yN_ready ignored, no underflow).
REQ-023 SHALL wrap read/write pointers modulo DEPTH; occupancy counter ranges 0..DEPTH.
REQ-024 SHALL increment cntN by 1 on each push to channel N, wrapping 255 -> 0.
REQ-025 SHALL treat s as sampled only in the accepting cycle; s changes without a push have no effect.

Reset
REQ-026 SHALL, while reset=1, asynchronously force: all occupancies 0, pointers 0, storage 0, y0_valid=y1_valid=0, y0=y1=0, cnt0=cnt1=0.
REQ-027 SHALL drive in_ready=1 during reset (both buffers empty) but SHALL ignore pushes while reset=1.
REQ-028 SHALL discard all buffered words on reset asserted mid-operation; no word survives reset.

Structure
REQ-029 SHALL place WIDTH/DEPTH defaults and the word typedef (logic [WIDTH-1:0]) in shared package demux_pkg.
REQ-030 SHALL implement each channel buffer as one instance of sub-module stream_fifo (push, pop, full, empty, head data, reset), instantiated twice.
REQ-031 SHALL keep steering logic (s decode, in_ready, cnt0/cnt1) in demux1_2_stream top only.

Verification
REQ-032 Reset release, in_valid=1, s=1, d=32'hDEADBEEF for 1 cycle -> next cycle y0_valid=1, y0=32'hDEADBEEF, y1_valid=0, cnt0=1.
REQ-033 y1_ready=0, push 32'h1, 32'h2, 32'h3 with s=0 (DEPTH=2) -> in_ready=0 on third cycle, third word not accepted, cnt1=2; then y1_ready=1 -> y1 reads 1 then 2.
REQ-034 Channel 1 full, s=0, in_valid=1, y1_ready=1 same cycle -> no push (in_ready=0), one pop; next cycle in_ready=1.
REQ-035 Alternate s=1/0 with d=10,11,12,13, both readies 1 -> y0 sees 10,12; y1 sees 11,13; cnt0=cnt1=2.
REQ-036 256 pushes to channel 0 with y0_ready=1 -> cnt0 wraps to 0; reset asserted with one word buffered -> y0_valid=0, y0=0, cnt0=0 immediately (asynchronous).
